neureka_normquant_shift_loader: RTL
===================================

Name: neureka_normquant_shift_loader

Overview:
- Producer side of the normquant shift-parameter interface.
- Accepts a 32-bit word stream (4 packed 8-bit shift amounts per word) from the weight/param streamer and assembles one NADD-lane shift vector.
- Presents that vector to the normquant bias/shift stage through a valid/ready handshake.
- Sits between the param streamer and the normquant datapath, one instance per accumulator bank.

Parameters:
- NADD, 8, number of shift lanes (multiple of 4, ≥4).
- MAX_SHIFT, 31, per-lane saturation limit for shift amounts.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous local clear, same effect as rst_i
- start_i  in  1  begin a load; sampled only in IDLE
- nb_lanes_i  in  $clog2(NADD)+1  valid lanes for this load; 0 means NADD; values >NADD treated as NADD
- data_i  in  32  packed shift bytes; byte k → lane 4*w+k for word w
- valid_i  in  1  data_i valid
- ready_o  out  1  loader accepts data_i
- shift_o  out  NADD*8  lane ii at [(ii+1)*8-1:ii*8]
- shift_valid_o  out  1  shift_o complete and stable
- shift_ready_i  in  1  normquant consumes shift_o
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on handoff

Behaviour:
- Reset/clear, checked every cycle, clear_i/rst_i has priority over all events: state=IDLE, shift regs=0, word counter=0, ready_o=0, shift_valid_o=0, done_o=0, busy_o=0.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - start_i=1 latches eff_lanes (resolved per nb_lanes_i rule) and words_needed=ceil(eff_lanes/4).
  - Zeroes all shift regs; goes to LOAD next cycle.
  - start_i in LOAD/HOLD is ignored.
- LOAD:
  - ready_o=1 combinationally while in LOAD.
  - Beat accepted when valid_i&&ready_o; word w writes lanes 4w..4w+3.
  - Lanes with index ≥eff_lanes are written 0.
  - Byte values >MAX_SHIFT are stored as MAX_SHIFT (unsigned compare).
  - On acceptance of word words_needed-1, go to HOLD; ready_o drops the following cycle.
  - Extra words are never accepted.
- HOLD:
  - shift_valid_o=1; shift_o frozen.
  - On shift_valid_o&&shift_ready_i: done_o=1 for that same cycle (combinational), state→IDLE; shift_o retains its values until the next start_i.
- Latency:
  - start_i to first ready_o: 1 cycle.
  - Last accepted word to shift_valid_o: 1 cycle.
  - Minimum load for NADD=8: start, 2 beats, handoff = 4 cycles.
- valid_i deasserted mid-LOAD: loader waits indefinitely; counter holds.
- shift_ready_i high before HOLD has no effect.
- Back-to-back operation: start_i may be asserted in the cycle after done_o.

Optional Feature:
- Macro: NEUREKA_NQ_SHIFT_REUSE_EN.
- With the macro: adds input reuse_i (1 bit), sampled with start_i in IDLE.
  - reuse_i=1 skips LOAD and goes directly to HOLD, re-presenting the previously loaded shift_o with shift_valid_o one cycle after start_i.
  - reuse_i=1 also skips latching nb_lanes_i and zeroing the shift regs.
  - reuse_i=0 performs a normal load.
- Without the macro: no reuse_i port; every start_i performs a full load.

Test Plan:
- NADD=8; start_i with nb_lanes_i=0; words 0x04030201, 0x08070605 → shift_valid_o after 2nd beat; shift_o lanes 0..7 = 1..8; done_o pulses on shift_ready_i.
- nb_lanes_i=5; words 0x0A0A0A0A, 0x0B0B0B0B → exactly 2 beats accepted; lane4=0x0B, lanes5..7=0, lanes0..3=0x0A.
- Word 0xFF20_1F00 → lanes 0..3 = 0, 31, 31, 31 (saturation at MAX_SHIFT).
- valid_i gapped 3 cycles between beats; shift_ready_i held low 5 cycles in HOLD → shift_o stable throughout; single done_o pulse.
- rst_i asserted after first beat accepted → next cycle IDLE, shift_o=0, ready_o=0; a new start_i loads correctly.
- With NEUREKA_NQ_SHIFT_REUSE_EN: load 1..8, handoff, then start_i with reuse_i=1 → shift_valid_o next cycle, shift_o=1..8, ready_o never asserted.

Source files
------------

// File: rtl/neureka_normquant_shift_loader.sv
// Packs 32-bit param words into an NADD-lane shift vector for the normquant stage.
// Optional reuse of the previous vector via `define NEUREKA_NQ_SHIFT_REUSE_EN.
module neureka_normquant_shift_loader #(
    parameter int unsigned NADD      = 8,
    parameter int unsigned MAX_SHIFT = 31
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
`ifdef NEUREKA_NQ_SHIFT_REUSE_EN
    input  logic                    reuse_i,
`endif
    input  logic [$clog2(NADD):0]   nb_lanes_i,
    input  logic [31:0]             data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [NADD*8-1:0]       shift_o,
    output logic                    shift_valid_o,
    input  logic                    shift_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned LW = $clog2(NADD) + 1;
    localparam int unsigned WW = $clog2(NADD / 4 + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NADD*8-1:0]  shift_q, shift_d;
    logic [WW-1:0]      cnt_q, cnt_d;
    logic [WW-1:0]      words_q, words_d;
    logic [LW-1:0]      eff_q, eff_d;
    logic [LW-1:0]      eff_res;
    logic [7:0]         byte_v;
    logic               reuse_req;

`ifdef NEUREKA_NQ_SHIFT_REUSE_EN
    assign reuse_req = reuse_i;
`else
    assign reuse_req = 1'b0;
`endif

    // Zero and oversize lane counts both mean "all lanes".
    assign eff_res = (nb_lanes_i == '0 || 32'(nb_lanes_i) > NADD) ? LW'(NADD) : nb_lanes_i;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        eff_d   = eff_q;
        byte_v  = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (reuse_req) begin
                        state_d = HOLD;
                    end else begin
                        eff_d   = eff_res;
                        words_d = WW'((32'(eff_res) + 32'd3) / 32'd4);
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (valid_i) begin
                    for (int unsigned ii = 0; ii < NADD; ii++) begin
                        if (ii / 4 == 32'(cnt_q)) begin
                            byte_v = data_i[(ii % 4) * 8 +: 8];
                            if (ii >= 32'(eff_q))
                                shift_d[ii*8 +: 8] = '0;
                            else if (byte_v > 8'(MAX_SHIFT))
                                shift_d[ii*8 +: 8] = 8'(MAX_SHIFT);
                            else
                                shift_d[ii*8 +: 8] = byte_v;
                        end
                    end
                    if (cnt_q == words_q - WW'(1)) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + WW'(1);
                    end
                end
            end
            HOLD: begin
                if (shift_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            eff_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            eff_q   <= eff_d;
        end
    end

    assign ready_o       = (state_q == LOAD);
    assign shift_valid_o = (state_q == HOLD);
    assign done_o        = (state_q == HOLD) && shift_ready_i;
    assign busy_o        = (state_q != IDLE);
    assign shift_o       = shift_q;

endmodule
